// File: rtl/niosballe_pio_pkg.sv
// Register map of the PIO pulse peripheral.
// Any block that decodes its Avalon-MM address space imports this package.
package niosballe_pio_pkg;

  typedef enum logic [2:0] {
    ADDR_DATA      = 3'd0,
    ADDR_RSVD1     = 3'd1,
    ADDR_PULSE_LEN = 3'd2,
    ADDR_MODE      = 3'd3,
    ADDR_OUTSET    = 3'd4,
    ADDR_OUTCLEAR  = 3'd5,
    ADDR_STATUS    = 3'd6,
    ADDR_RSVD7     = 3'd7
  } pio_addr_e;

  localparam int STATUS_BUSY_BIT = 0;

endpackage

// File: rtl/niosballe_pio_pulse_timer.sv
// Shared pulse timer: one down-counter and busy flag for all pulse-mode bits.
// Expiry is flagged combinationally on the last counted cycle unless a new start reloads it.
module niosballe_pio_pulse_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  output logic             busy,
  output logic             expire
);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] load_val;

  // A zero length still produces a one-cycle pulse.
  assign load_val = (len == '0) ? CNT_W'(1) : len;
  assign expire   = busy && (count == CNT_W'(1)) && !start;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      busy  <= 1'b0;
    end else if (start) begin
      count <= load_val;
      busy  <= 1'b1;
    end else if (expire) begin
      count <= '0;
      busy  <= 1'b0;
    end else if (busy) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/niosballe_pio_pulse.sv
// Avalon-MM PIO with per-bit pulse mode: register file, write decode and read mux.
// Pulse-mode bits are cleared together when the shared timer expires.
module niosballe_pio_pulse
  import niosballe_pio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               CNT_W       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] data_next;
  logic [WIDTH-1:0] mode;
  logic [WIDTH-1:0] wdata;
  logic [CNT_W-1:0] pulse_len;
  logic             wr_en;
  logic             wr_data;
  logic             wr_len;
  logic             wr_mode;
  logic             wr_set;
  logic             wr_clr;
  logic             start;
  logic             busy;
  logic             expire;
  logic             unused_wdata;

  assign wr_en        = chipselect && !write_n;
  assign wr_data      = wr_en && (address == ADDR_DATA);
  assign wr_len       = wr_en && (address == ADDR_PULSE_LEN);
  assign wr_mode      = wr_en && (address == ADDR_MODE);
  assign wr_set       = wr_en && (address == ADDR_OUTSET);
  assign wr_clr       = wr_en && (address == ADDR_OUTCLEAR);
  assign wdata        = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;

  // Writing a 1 into any pulse-mode bit (re)starts the shared timer, even if it is already high.
  assign start = (wr_data || wr_set) && ((wdata & mode) != '0);

  niosballe_pio_pulse_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .len    (pulse_len),
    .busy   (busy),
    .expire (expire)
  );

  always_comb begin
    data_next = data;
    if (wr_data) begin
      data_next = wdata;
    end else if (wr_set) begin
      data_next = data | wdata;
    end else if (wr_clr) begin
      data_next = data & ~wdata;
    end
    if (expire) begin
      data_next = data_next & ~mode;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data      <= RESET_VALUE;
      mode      <= '0;
      pulse_len <= CNT_W'(1);
    end else begin
      data <= data_next;
      if (wr_len) begin
        pulse_len <= writedata[CNT_W-1:0];
      end
      if (wr_mode) begin
        mode <= wdata;
      end
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:      readdata = 32'(data);
      ADDR_PULSE_LEN: readdata = 32'(pulse_len);
      ADDR_MODE:      readdata = 32'(mode);
      ADDR_STATUS:    readdata[STATUS_BUSY_BIT] = busy;
      default:        readdata = '0;
    endcase
  end

  assign out_port = data;

endmodule

// File: tb/tb_niosballe_pio_pulse.sv
// Self-checking bench for niosballe_pio_pulse: register vectors from a table, then pulse sequences.
// Each step queues the out_port/readdata expected during that cycle and checks them on the falling edge.
module tb_niosballe_pio_pulse;

  typedef struct {
    logic        rst;
    logic        cs;
    logic        wn;
    logic [2:0]  addr;
    logic [31:0] wd;
    logic [7:0]  exp_out;
    logic [31:0] exp_rd;
  } vec_t;

  typedef struct {
    int          id;
    logic [7:0]  exp_out;
    logic [31:0] exp_rd;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  int   checks = 0;
  int   errors = 0;
  int   step_id = 0;
  exp_t sb[$];
  vec_t tbl[$];

  niosballe_pio_pulse #(
    .WIDTH       (8),
    .CNT_W       (16),
    .RESET_VALUE (8'h5A)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  function automatic vec_t v(input logic rst, input logic cs, input logic wn, input logic [2:0] a,
                             input logic [31:0] d, input logic [7:0] eo, input logic [31:0] er);
    vec_t r;
    r.rst = rst; r.cs = cs; r.wn = wn; r.addr = a; r.wd = d; r.exp_out = eo; r.exp_rd = er;
    return r;
  endfunction

  function automatic vec_t wr(input logic [2:0] a, input logic [31:0] d, input logic [7:0] eo,
                              input logic [31:0] er);
    return v(1'b0, 1'b1, 1'b0, a, d, eo, er);
  endfunction

  function automatic vec_t rd(input logic [2:0] a, input logic [7:0] eo, input logic [31:0] er);
    return v(1'b0, 1'b0, 1'b1, a, 32'h0, eo, er);
  endfunction

  function automatic vec_t rst_rd(input logic [2:0] a, input logic [7:0] eo, input logic [31:0] er);
    return v(1'b1, 1'b0, 1'b1, a, 32'h0, eo, er);
  endfunction

  task automatic check_output();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_empty: got no queued expectation, required one");
      return;
    end
    e = sb.pop_front();
    if (out_port !== e.exp_out) begin
      errors++;
      $display("[TB] FAIL step%0d out_port: got 0x%02h required 0x%02h", e.id, out_port, e.exp_out);
    end
    checks++;
    if (readdata !== e.exp_rd) begin
      errors++;
      $display("[TB] FAIL step%0d readdata: got 0x%08h required 0x%08h", e.id, readdata, e.exp_rd);
    end
  endtask

  task automatic apply_stimulus(input vec_t t);
    exp_t e;
    reset      = t.rst;
    chipselect = t.cs;
    write_n    = t.wn;
    address    = t.addr;
    writedata  = t.wd;
    e.id = step_id; e.exp_out = t.exp_out; e.exp_rd = t.exp_rd;
    sb.push_back(e);
    step_id++;
    @(negedge clk);
    check_output();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Register access vectors, starting right after reset (DATA=0x5A, MODE=0, PULSE_LEN=1).
    tbl.push_back(rd(3'd0, 8'h5A, 32'h5A));
    tbl.push_back(rd(3'd3, 8'h5A, 32'h0));
    tbl.push_back(rd(3'd2, 8'h5A, 32'h1));
    tbl.push_back(rd(3'd6, 8'h5A, 32'h0));
    tbl.push_back(wr(3'd0, 32'hA5, 8'h5A, 32'h5A));
    tbl.push_back(rd(3'd0, 8'hA5, 32'hA5));
    tbl.push_back(wr(3'd0, 32'hFFFFFF0F, 8'hA5, 32'hA5));
    tbl.push_back(rd(3'd0, 8'h0F, 32'h0F));
    tbl.push_back(wr(3'd4, 32'h30, 8'h0F, 32'h0));
    tbl.push_back(rd(3'd0, 8'h3F, 32'h3F));
    tbl.push_back(wr(3'd5, 32'h03, 8'h3F, 32'h0));
    tbl.push_back(rd(3'd0, 8'h3C, 32'h3C));
    tbl.push_back(wr(3'd1, 32'hFF, 8'h3C, 32'h0));
    tbl.push_back(wr(3'd7, 32'hFF, 8'h3C, 32'h0));
    tbl.push_back(wr(3'd6, 32'hFF, 8'h3C, 32'h0));
    tbl.push_back(rd(3'd0, 8'h3C, 32'h3C));
    tbl.push_back(wr(3'd2, 32'h12345, 8'h3C, 32'h1));
    tbl.push_back(rd(3'd2, 8'h3C, 32'h2345));
    tbl.push_back(wr(3'd3, 32'hF0F, 8'h3C, 32'h0));
    tbl.push_back(rd(3'd3, 8'h3C, 32'h0F));
    tbl.push_back(wr(3'd3, 32'h0, 8'h3C, 32'h0F));
    tbl.push_back(rd(3'd5, 8'h3C, 32'h0));
    tbl.push_back(v(1'b0, 1'b0, 1'b0, 3'd0, 32'h00, 8'h3C, 32'h3C));
    tbl.push_back(v(1'b0, 1'b1, 1'b1, 3'd0, 32'h00, 8'h3C, 32'h3C));
    tbl.push_back(rd(3'd0, 8'h3C, 32'h3C));

    reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = 3'd0; writedata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) apply_stimulus(tbl[i]);

    // Basic 5-cycle pulse on bit0 with a non-pulse bit7 set.
    apply_stimulus(wr(3'd2, 32'd5, 8'h3C, 32'h2345));
    apply_stimulus(wr(3'd3, 32'h01, 8'h3C, 32'h0));
    apply_stimulus(wr(3'd0, 32'h80, 8'h3C, 32'h3C));
    apply_stimulus(wr(3'd4, 32'h01, 8'h80, 32'h0));
    for (int i = 0; i < 5; i++) apply_stimulus(rd(3'd6, 8'h81, 32'h1));
    for (int i = 0; i < 2; i++) apply_stimulus(rd(3'd6, 8'h80, 32'h0));

    // Retrigger two cycles in: six cycles high in total.
    apply_stimulus(wr(3'd2, 32'd4, 8'h80, 32'd5));
    apply_stimulus(wr(3'd4, 32'h01, 8'h80, 32'h0));
    apply_stimulus(rd(3'd6, 8'h81, 32'h1));
    apply_stimulus(wr(3'd4, 32'h01, 8'h81, 32'h0));
    for (int i = 0; i < 4; i++) apply_stimulus(rd(3'd6, 8'h81, 32'h1));
    apply_stimulus(rd(3'd6, 8'h80, 32'h0));

    // Zero length behaves as one cycle.
    apply_stimulus(wr(3'd2, 32'd0, 8'h80, 32'd4));
    apply_stimulus(rd(3'd2, 8'h80, 32'h0));
    apply_stimulus(wr(3'd4, 32'h01, 8'h80, 32'h0));
    apply_stimulus(rd(3'd6, 8'h81, 32'h1));
    apply_stimulus(rd(3'd6, 8'h80, 32'h0));

    // Restart exactly on the expiry cycle: no low glitch, busy stays set.
    apply_stimulus(wr(3'd2, 32'd3, 8'h80, 32'h0));
    apply_stimulus(wr(3'd4, 32'h01, 8'h80, 32'h0));
    for (int i = 0; i < 2; i++) apply_stimulus(rd(3'd6, 8'h81, 32'h1));
    apply_stimulus(wr(3'd4, 32'h01, 8'h81, 32'h0));
    for (int i = 0; i < 3; i++) apply_stimulus(rd(3'd6, 8'h81, 32'h1));
    apply_stimulus(rd(3'd6, 8'h80, 32'h0));

    // Start via DATA, early OUTCLEAR of a pulse bit, OUTCLEAR coincident with expiry.
    apply_stimulus(wr(3'd3, 32'h03, 8'h80, 32'h1));
    apply_stimulus(wr(3'd0, 32'h83, 8'h80, 32'h80));
    apply_stimulus(wr(3'd5, 32'h02, 8'h83, 32'h0));
    apply_stimulus(rd(3'd6, 8'h81, 32'h1));
    apply_stimulus(wr(3'd5, 32'h80, 8'h81, 32'h0));
    apply_stimulus(rd(3'd6, 8'h00, 32'h0));

    // MODE bit dropped mid-pulse keeps its value past expiry.
    apply_stimulus(wr(3'd0, 32'h03, 8'h00, 32'h00));
    apply_stimulus(wr(3'd3, 32'h01, 8'h03, 32'h03));
    for (int i = 0; i < 2; i++) apply_stimulus(rd(3'd6, 8'h03, 32'h1));
    apply_stimulus(rd(3'd6, 8'h02, 32'h0));

    // PULSE_LEN written while busy only applies to the next start.
    apply_stimulus(wr(3'd4, 32'h01, 8'h02, 32'h0));
    apply_stimulus(wr(3'd2, 32'd6, 8'h03, 32'd3));
    for (int i = 0; i < 2; i++) apply_stimulus(rd(3'd6, 8'h03, 32'h1));
    apply_stimulus(rd(3'd6, 8'h02, 32'h0));
    apply_stimulus(wr(3'd4, 32'h01, 8'h02, 32'h0));
    for (int i = 0; i < 6; i++) apply_stimulus(rd(3'd6, 8'h03, 32'h1));
    apply_stimulus(rd(3'd6, 8'h02, 32'h0));

    // Reset on cycle 2 of a 10-cycle pulse aborts it.
    apply_stimulus(wr(3'd2, 32'd10, 8'h02, 32'd6));
    apply_stimulus(wr(3'd4, 32'h01, 8'h02, 32'h0));
    apply_stimulus(rd(3'd6, 8'h03, 32'h1));
    apply_stimulus(rst_rd(3'd6, 8'h03, 32'h1));
    apply_stimulus(rst_rd(3'd3, 8'h5A, 32'h0));
    apply_stimulus(rd(3'd2, 8'h5A, 32'h1));
    apply_stimulus(rd(3'd3, 8'h5A, 32'h0));
    for (int i = 0; i < 12; i++) apply_stimulus(rd(3'd6, 8'h5A, 32'h0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/niosballe_pio_pulse.md
NIOSBALLE_PIO_PULSE -- requirements
Module: niosballe_pio_pulse

Interface
REQ-001 Parameter WIDTH, default 8, number of output bits (legal 1..32).
REQ-002 Parameter CNT_W, default 16, pulse-length counter width (legal 1..24).
REQ-003 Parameter RESET_VALUE, default 0, WIDTH-bit value of the DATA register after reset.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 address  input  3  Avalon-MM word address.
REQ-007 chipselect  input  1  slave select.
REQ-008 write_n  input  1  active-low write strobe.
REQ-009 writedata  input  32  write data; bits above the field width are ignored.
REQ-010 readdata  output  32  read data, zero-extended; zero wait states, zero read latency.
REQ-011 out_port  output  WIDTH  output pins, driven directly from the DATA register.

Function
REQ-012 A write occurs only in a cycle with chipselect=1 and write_n=0; out_port reflects it on the following cycle.
REQ-013 Register map: 0 DATA (rw), 2 PULSE_LEN (rw, CNT_W bits), 3 MODE (rw, WIDTH bits, 1=pulse mode per bit), 4 OUTSET (wo), 5 OUTCLEAR (wo), 6 STATUS (ro, bit0=busy); 1 and 7 are reserved.
REQ-014 Reads of OUTSET, OUTCLEAR, 1 and 7 shall return 0; writes to 1, 6 and 7 shall be ignored.
REQ-015 A DATA write loads DATA with writedata[WIDTH-1:0].
REQ-016 An OUTSET write performs DATA |= writedata; an OUTCLEAR write performs DATA &= ~writedata.
REQ-017 A pulse start is any DATA or OUTSET write that drives to 1 at least one bit whose MODE bit is 1.
REQ-018 On a pulse start, the shared counter loads L = max(PULSE_LEN,1) and busy is set.
REQ-019 The counter decrements by 1 each cycle while busy; no wrap-around is permitted.
REQ-020 Expiry occurs when the counter is 1 and no pulse start occurs in the same cycle.
REQ-021 On expiry, DATA bits with MODE=1 clear, busy clears, and bits with MODE=0 are untouched.
REQ-022 A pulse bit shall stay high for exactly L cycles of out_port.
REQ-023 A pulse start while busy reloads the counter to L; all active pulse bits are extended to the new expiry.
REQ-024 A pulse start coincident with expiry wins: the counter reloads, bits stay or become high, and busy stays 1.
REQ-025 An OUTCLEAR write coincident with expiry clears the union of both; busy is unaffected by OUTCLEAR.
REQ-026 A pulse-mode bit cleared by OUTCLEAR or DATA before expiry stays 0; the counter keeps running.
REQ-027 A MODE bit changed to 0 while busy keeps its current DATA value and is not cleared at expiry.
REQ-028 A PULSE_LEN write while busy takes effect only at the next pulse start.

Reset
REQ-029 While reset=1 at a clk edge: DATA=RESET_VALUE, MODE=0, PULSE_LEN=1, counter=0, busy=0.
REQ-030 Reset asserted mid-pulse aborts the pulse; no expiry-clear occurs afterward.
REQ-031 During reset, readdata shall remain a function of address and register state only.

Structure
REQ-032 Package niosballe_pio_pkg shall hold the register address constants (ADDR_DATA..ADDR_STATUS).
REQ-033 Sub-module niosballe_pio_pulse_timer (inputs: start, len; outputs: busy, expire) shall hold the counter and busy flag.
REQ-034 The top module shall hold the register file, the write decode and the combinational read mux.

Verification
REQ-035 WIDTH=8: write DATA=0xA5 -> out_port=0xA5 next cycle; read addr0 -> 0x000000A5.
REQ-036 DATA=0x0F, OUTSET 0x30, then OUTCLEAR 0x03 -> out_port 0x3F then 0x3C.
REQ-037 MODE=0x01, PULSE_LEN=5, OUTSET 0x01 -> out_port[0] high exactly 5 cycles; STATUS=1 during the pulse, 0 after.
REQ-038 PULSE_LEN=4, OUTSET 0x01, second OUTSET 0x01 two cycles later -> bit0 high 6 cycles total; also PULSE_LEN=0 -> 1-cycle pulse.
REQ-039 Pulse start on the exact expiry cycle -> no low glitch on out_port, busy stays 1.
REQ-040 reset=1 at cycle 2 of a 10-cycle pulse -> out_port=RESET_VALUE, STATUS=0, MODE reads 0, PULSE_LEN reads 1.
